picosoc_bus_arbiter: RTL and testbench
======================================

Name: picosoc_bus_arbiter

Overview:
- Two-master arbiter for the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets a second requester (DMA engine or second core) share the picosoc slave fabric with the CPU: RAM, spimemio, simpleuart, iomem.
- Round-robin grant; one transaction at a time.
- Per-transaction timeout watchdog, so a hung slave cannot stall both masters.

Parameters:
- TIMEOUT, 256: BUSY cycles without s_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hBADB_AD00: rdata returned to the master on timeout.
- RESET_PRIO, 0: master given priority in the first arbitration after reset.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction-fetch qualifier
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes (0 = read)
- m0_ready  out  1  master 0 completion pulse
- m0_rdata  out  32  master 0 read data
- m1_*  same set and widths as m0_*, for master 1
- s_valid  out  1  request to slave fabric
- s_instr  out  1  forwarded instr qualifier
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_wstrb  out  4  forwarded strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  1  index of the current or last granted master
- timeout_irq  out  1  one-cycle pulse on timeout
- timeout_sticky  out  1  latched timeout flag
- timeout_clr  in  1  clears timeout_sticky

Behaviour:
- Reset (async, resetn low):
  - state=IDLE, grant=RESET_PRIO, last=~RESET_PRIO, counter=0.
  - timeout_sticky=0, timeout_irq=0.
  - s_valid=0, m0_ready=0, m1_ready=0.
- States: IDLE, BUSY.
- IDLE:
  - s_valid=0; all m_ready=0.
  - If either m_valid is high, register the winner into grant and go to BUSY next edge.
  - Winner: the sole requester; if both request, the master != last.
- BUSY:
  - s_valid = m_valid[grant]; s_addr/s_wdata/s_wstrb/s_instr are mux[grant], combinational.
  - s_ready high: m_ready[grant]=1 in the same cycle; m_rdata[grant]=s_rdata; last<=grant; go to IDLE.
  - Non-granted master: ready=0, rdata=0.
- Latency:
  - Arbitration adds exactly one cycle: request seen in IDLE cycle N, s_valid high in cycle N+1.
  - The mandatory IDLE cycle after every completion guarantees s_valid drops the cycle after s_ready. Required by the RAM ready/wen logic.
- Outputs when not BUSY: s_addr/s_wdata/s_wstrb/s_instr hold mux[grant], but s_valid=0.
- Abort: if m_valid[grant] drops during BUSY without s_ready, go to IDLE; no m_ready; last unchanged.
- Watchdog:
  - counter increments each BUSY cycle; clears on entry to BUSY.
  - With TIMEOUT!=0, in the BUSY cycle where counter==TIMEOUT-1 and s_ready=0:
    - s_valid forced 0; m_ready[grant]=1; m_rdata[grant]=ERR_RDATA.
    - timeout_irq=1 for that cycle; timeout_sticky<=1; last<=grant; go to IDLE.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no irq.
  - Counter width is clog2(TIMEOUT+1) and never wraps.
- timeout_clr and a new timeout in the same cycle: the set wins.
- Writes: wstrb is forwarded unchanged; the arbiter never merges or splits transactions.
- Reset mid-transaction returns to IDLE immediately with no m_ready. The in-flight slave access is abandoned.

Decomposition:
- Shared package picosoc_bus_pkg:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - ERR_RDATA default
  - native-bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4)
- One sub-module, picosoc_rr_pick: 2-input round-robin picker; inputs req[1:0] and last; outputs gnt_idx and any.

Test Plan:
- m0 read of 0x0000_0010 alone; slave readies 2 cycles after s_valid with 0x1234_5678 -> s_valid rises 1 cycle after m0_valid; m0_ready pulse carries rdata 0x1234_5678; s_valid low the next cycle; m1_ready stays 0.
- m0 and m1 both request continuously, slave ready in 1 cycle -> grants alternate 0,1,0,1 (RESET_PRIO=0); each transaction occupies 3 cycles including the IDLE bubble.
- m1 write 0x0200_0008, wstrb 4'b0001, wdata 0x41 -> slave sees identical addr/wdata/wstrb; m1_ready pulses once; m0 idle.
- TIMEOUT=8, slave never readies -> at BUSY cycle 8: m_ready=1 with rdata 0xBADB_AD00, timeout_irq one pulse, timeout_sticky=1, s_valid=0; timeout_clr pulse then clears sticky.
- s_ready asserted exactly on BUSY cycle 8 with TIMEOUT=8 -> normal rdata, no timeout_irq.
- resetn asserted low mid-BUSY -> s_valid, m_ready and grant return to reset values immediately (async); after release, the first arbitration follows RESET_PRIO.

Source files
------------

// File: rtl/picosoc_bus_pkg.sv
// Shared definitions for the PicoRV32 native-bus arbiter: FSM encoding,
// bus field widths and the default error read data.
package picosoc_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hBADB_AD00;

endpackage

// File: rtl/picosoc_rr_pick.sv
// Two-requester round-robin picker: a sole requester wins outright,
// a tie goes to the master that was not served last.
module picosoc_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    assign any     = |req;
    assign gnt_idx = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native bus with a
// per-transaction watchdog that force-completes a hung slave access.
module picosoc_bus_arbiter
    import picosoc_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT    = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA  = ERR_RDATA_DEF,
    parameter logic              RESET_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              grant,
    output logic              timeout_irq,
    output logic              timeout_sticky,
    input  logic              timeout_clr
);

    // A zero TIMEOUT still needs a legal one-bit counter, it is simply never compared.
    localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic             WDOG_EN  = (TIMEOUT != 0);

    state_t            r_state;
    state_t            w_next;
    logic              r_grant;
    logic              r_last;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_pick;
    logic              w_any;
    logic              w_mvalid;
    logic              w_busy;
    logic              w_done;
    logic              w_to;
    logic              w_ack;
    logic [DATA_W-1:0] w_rdata;

    picosoc_rr_pick u_pick (
        .req     ({m1_valid, m0_valid}),
        .last    (r_last),
        .gnt_idx (w_pick),
        .any     (w_any)
    );

    assign w_mvalid = r_grant ? m1_valid : m0_valid;
    assign w_busy   = (r_state == ST_BUSY);
    assign w_done   = w_busy && w_mvalid && s_ready;
    assign w_to     = WDOG_EN && w_busy && w_mvalid && !s_ready && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_BUSY;
            ST_BUSY: if (!w_mvalid || w_done || w_to) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_valid     = w_busy && w_mvalid && !w_to;
        w_ack       = w_done || w_to;
        w_rdata     = w_to ? ERR_RDATA : s_rdata;
        m0_ready    = w_ack && !r_grant;
        m1_ready    = w_ack && r_grant;
        m0_rdata    = m0_ready ? w_rdata : '0;
        m1_rdata    = m1_ready ? w_rdata : '0;
        s_instr     = r_grant ? m1_instr : m0_instr;
        s_addr      = r_grant ? m1_addr  : m0_addr;
        s_wdata     = r_grant ? m1_wdata : m0_wdata;
        s_wstrb     = r_grant ? m1_wstrb : m0_wstrb;
        timeout_irq = w_to;
    end

    assign grant          = r_grant;
    assign timeout_sticky = r_sticky;

    // Counter is held at zero while idle, so every BUSY entry starts from zero; it saturates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant  <= RESET_PRIO;
            r_last   <= ~RESET_PRIO;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
                if (w_any) r_grant <= w_pick;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_ack) r_last <= r_grant;
            if (w_to)             r_sticky <= 1'b1;
            else if (timeout_clr) r_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Directed bench for picosoc_bus_arbiter with an 8-cycle watchdog.
module tb_picosoc_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant, timeout_irq, timeout_sticky, timeout_clr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    picosoc_bus_arbiter #(
        .TIMEOUT    (8),
        .ERR_RDATA  (32'hBADB_AD00),
        .RESET_PRIO (1'b0)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .m0_valid       (m0_valid),
        .m0_instr       (m0_instr),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_wstrb       (m0_wstrb),
        .m0_ready       (m0_ready),
        .m0_rdata       (m0_rdata),
        .m1_valid       (m1_valid),
        .m1_instr       (m1_instr),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_wstrb       (m1_wstrb),
        .m1_ready       (m1_ready),
        .m1_rdata       (m1_rdata),
        .s_valid        (s_valid),
        .s_instr        (s_instr),
        .s_addr         (s_addr),
        .s_wdata        (s_wdata),
        .s_wstrb        (s_wstrb),
        .s_ready        (s_ready),
        .s_rdata        (s_rdata),
        .grant          (grant),
        .timeout_irq    (timeout_irq),
        .timeout_sticky (timeout_sticky),
        .timeout_clr    (timeout_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0; timeout_clr = 0;
        resetn = 0;
        step();
        step();
        resetn = 1;
    endtask

    logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // reset state
        do_reset();
        #1;
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_irq", 32'(timeout_irq), 32'd0);
        chk("rst_sticky", 32'(timeout_sticky), 32'd0);

        // m0 read alone, slave ready on the 3rd BUSY cycle
        step();
        m0_valid = 1; m0_instr = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'b0000;
        #1 chk("t1_idle_s_valid", 32'(s_valid), 32'd0);
        step();
        chk("t1_s_valid", 32'(s_valid), 32'd1);
        chk("t1_s_addr", s_addr, 32'h0000_0010);
        chk("t1_s_instr", 32'(s_instr), 32'd1);
        chk("t1_early_ready", 32'(m0_ready), 32'd0);
        step();
        chk("t1_wait_ready", 32'(m0_ready), 32'd0);
        step();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        chk("t1_m0_ready", 32'(m0_ready), 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_ready", 32'(m1_ready), 32'd0);
        chk("t1_m1_rdata", m1_rdata, 32'd0);
        step();
        s_ready = 0; m0_valid = 0; m0_instr = 0;
        #1;
        chk("t1_s_valid_drop", 32'(s_valid), 32'd0);
        chk("t1_m0_ready_drop", 32'(m0_ready), 32'd0);

        // both masters request continuously: grants alternate from reset priority
        do_reset();
        m0_valid = 1; m0_addr = 32'h0000_0100;
        m1_valid = 1; m1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_idle_s_valid", 32'(s_valid), 32'd0);
            step();
            chk("t2_grant", 32'(grant), 32'(exp_g[i]));
            chk("t2_s_addr", s_addr, exp_g[i] ? 32'h0000_0200 : 32'h0000_0100);
            chk("t2_busy_s_valid", 32'(s_valid), 32'd1);
            step();
            s_ready = 1; s_rdata = 32'hA000_0000 + 32'(i);
            #1;
            chk("t2_m0_ready", 32'(m0_ready), exp_g[i] ? 32'd0 : 32'd1);
            chk("t2_m1_ready", 32'(m1_ready), exp_g[i] ? 32'd1 : 32'd0);
            step();
            s_ready = 0;
        end
        m0_valid = 0; m1_valid = 0;

        // m1 byte write, forwarded unchanged
        step();
        m1_valid = 1; m1_addr = 32'h0200_0008; m1_wdata = 32'h0000_0041; m1_wstrb = 4'b0001;
        step();
        chk("t3_grant", 32'(grant), 32'd1);
        chk("t3_s_valid", 32'(s_valid), 32'd1);
        chk("t3_s_addr", s_addr, 32'h0200_0008);
        chk("t3_s_wdata", s_wdata, 32'h0000_0041);
        chk("t3_s_wstrb", 32'(s_wstrb), 32'h1);
        s_ready = 1;
        #1;
        chk("t3_m1_ready", 32'(m1_ready), 32'd1);
        chk("t3_m0_ready", 32'(m0_ready), 32'd0);
        step();
        s_ready = 0; m1_valid = 0;
        #1 chk("t3_m1_ready_once", 32'(m1_ready), 32'd0);

        // watchdog: slave never readies
        step();
        m0_valid = 1; m0_addr = 32'h0000_0040;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c < 8) begin
                chk("t4_wait_s_valid", 32'(s_valid), 32'd1);
                chk("t4_wait_irq", 32'(timeout_irq), 32'd0);
            end else begin
                chk("t4_to_m0_ready", 32'(m0_ready), 32'd1);
                chk("t4_to_rdata", m0_rdata, 32'hBADB_AD00);
                chk("t4_to_irq", 32'(timeout_irq), 32'd1);
                chk("t4_to_s_valid", 32'(s_valid), 32'd0);
            end
        end
        step();
        m0_valid = 0;
        #1;
        chk("t4_sticky_set", 32'(timeout_sticky), 32'd1);
        chk("t4_irq_pulse", 32'(timeout_irq), 32'd0);
        timeout_clr = 1;
        step();
        timeout_clr = 0;
        #1 chk("t4_sticky_clr", 32'(timeout_sticky), 32'd0);

        // s_ready on the watchdog cycle wins
        m0_valid = 1;
        for (int c = 1; c <= 8; c++) step();
        s_ready = 1; s_rdata = 32'hCAFE_0001;
        #1;
        chk("t5_m0_ready", 32'(m0_ready), 32'd1);
        chk("t5_rdata", m0_rdata, 32'hCAFE_0001);
        chk("t5_irq", 32'(timeout_irq), 32'd0);
        chk("t5_s_valid", 32'(s_valid), 32'd1);
        step();
        s_ready = 0; m0_valid = 0;
        #1 chk("t5_sticky", 32'(timeout_sticky), 32'd0);

        // asynchronous reset in the middle of a BUSY transaction
        step();
        m1_valid = 1;
        step();
        chk("t6_grant_busy", 32'(grant), 32'd1);
        chk("t6_s_valid_busy", 32'(s_valid), 32'd1);
        #2 resetn = 0;
        #1;
        chk("t6_rst_s_valid", 32'(s_valid), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_m1_ready", 32'(m1_ready), 32'd0);
        m0_valid = 1;
        step();
        resetn = 1;
        step();
        chk("t6_post_grant", 32'(grant), 32'd0);
        chk("t6_post_s_valid", 32'(s_valid), 32'd1);
        s_ready = 1;
        #1 chk("t6_post_m0_ready", 32'(m0_ready), 32'd1);
        step();
        s_ready = 0; m0_valid = 0; m1_valid = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
